// File: rtl/axis_byte_packer_pkg.sv
// Shared types and helpers for the byte packer stream stages.
package axis_pack_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pack_state_e;

    localparam int DEF_OUT_BYTES = 4;

    // Number of set lanes in a keep mask of up to 8 lanes.
    function automatic logic [3:0] popcount(input logic [7:0] mask);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_byte_packer_out_slice.sv
// Registered AXI Stream output slot: loads a word, holds it under backpressure.
module axis_out_slice
    import axis_pack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              Aclk,
    input  logic              Areset_n,
    input  logic              vld_p0,
    input  logic [DATA_W-1:0] data_p0,
    input  logic [KEEP_W-1:0] keep_p0,
    input  logic              last_p0,
    output logic              slot_free,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last
);

    assign slot_free = !m_valid || m_ready;

    // p0 -> p1: output register; a new load wins over a draining handshake
    always_ff @(posedge Aclk or negedge Areset_n) begin
        if (!Areset_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (vld_p0) begin
            m_valid <= 1'b1;
            m_data  <= data_p0;
            m_keep  <= keep_p0;
            m_last  <= last_p0;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_byte_packer.sv
// Packs 8-bit AXI Stream beats into OUT_BYTES-wide little-endian words.
// Optional AXIS_PACK_STATS_EN adds pkt_count/byte_count handshake counters.
module axis_byte_packer
    import axis_pack_pkg::*;
#(
    parameter int OUT_BYTES = DEF_OUT_BYTES
) (
    input  logic                   Aclk,
    input  logic                   Areset_n,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [7:0]             s_axis_tdata,
    input  logic [1:0]             s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [8*OUT_BYTES-1:0] m_axis_tdata,
    output logic [OUT_BYTES-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast
`ifdef AXIS_PACK_STATS_EN
    ,
    output logic [15:0]            pkt_count,
    output logic [31:0]            byte_count
`endif
);

    localparam int IDX_W = $clog2(OUT_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

    pack_state_e              state, state_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic [8*OUT_BYTES-1:0]   acc_data, acc_data_nxt, word_data_p0;
    logic [OUT_BYTES-1:0]     acc_keep, acc_keep_nxt, word_keep_p0;
    logic                     slot_free, accept, kept, complete_p0;
    logic                     unused_keep1;

    assign unused_keep1  = s_axis_tkeep[1];
    assign s_axis_tready = Areset_n && slot_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign kept          = accept && s_axis_tkeep[0];

    always_comb begin
        word_data_p0 = acc_data;
        word_keep_p0 = acc_keep;
        state_nxt    = state;
        idx_nxt      = idx;
        acc_data_nxt = acc_data;
        acc_keep_nxt = acc_keep;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (kept && idx == IDX_W'(i)) begin
                word_data_p0[i*8 +: 8] = s_axis_tdata;
                word_keep_p0[i]        = 1'b1;
            end
        end
        // A tlast beat closes the word even when it carries no byte.
        complete_p0 = accept && (s_axis_tlast || (kept && idx == LAST_IDX));
        if (complete_p0) begin
            state_nxt    = IDLE;
            idx_nxt      = '0;
            acc_data_nxt = '0;
            acc_keep_nxt = '0;
        end else if (kept) begin
            state_nxt    = ACCUM;
            idx_nxt      = idx + IDX_W'(1);
            acc_data_nxt = word_data_p0;
            acc_keep_nxt = word_keep_p0;
        end
    end

    always_ff @(posedge Aclk or negedge Areset_n) begin
        if (!Areset_n) begin
            state    <= IDLE;
            idx      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            acc_data <= acc_data_nxt;
            acc_keep <= acc_keep_nxt;
        end
    end

    axis_out_slice #(
        .DATA_W(8*OUT_BYTES),
        .KEEP_W(OUT_BYTES)
    ) u_out_slice (
        .Aclk     (Aclk),
        .Areset_n (Areset_n),
        .vld_p0   (complete_p0),
        .data_p0  (word_data_p0),
        .keep_p0  (word_keep_p0),
        .last_p0  (s_axis_tlast),
        .slot_free(slot_free),
        .m_valid  (m_axis_tvalid),
        .m_ready  (m_axis_tready),
        .m_data   (m_axis_tdata),
        .m_keep   (m_axis_tkeep),
        .m_last   (m_axis_tlast)
    );

`ifdef AXIS_PACK_STATS_EN
    always_ff @(posedge Aclk or negedge Areset_n) begin
        if (!Areset_n) begin
            pkt_count  <= '0;
            byte_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
            byte_count <= byte_count + 32'(popcount(8'(m_axis_tkeep)));
        end
    end
`endif

endmodule

// File: tb/tb_axis_byte_packer.sv
// Randomized and directed bench for axis_byte_packer against a list-based packing model.
module tb_axis_byte_packer;

    localparam int OB = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [8*OB-1:0] data;
        logic [OB-1:0]   keep;
        logic            last;
    } word_t;

    logic            Aclk = 1'b0;
    logic            Areset_n = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [7:0]      s_axis_tdata = '0;
    logic [1:0]      s_axis_tkeep = '0;
    logic            s_axis_tlast = 1'b0;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [8*OB-1:0] m_axis_tdata;
    logic [OB-1:0]   m_axis_tkeep;
    logic            m_axis_tlast;
`ifdef AXIS_PACK_STATS_EN
    logic [15:0]     pkt_count;
    logic [31:0]     byte_count;
`endif

    int checks = 0;
    int errors = 0;
    beat_t beats_q[$];
    word_t got_q[$];
    word_t exp_q[$];

    always #5 Aclk = ~Aclk;

    axis_byte_packer #(.OUT_BYTES(OB)) dut (
        .Aclk         (Aclk),
        .Areset_n     (Areset_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast)
`ifdef AXIS_PACK_STATS_EN
        ,
        .pkt_count    (pkt_count),
        .byte_count   (byte_count)
`endif
    );

    // Record every output handshake; sampled mid-cycle, it completes at the next rising edge.
    always @(negedge Aclk) begin
        if (Areset_n && m_axis_tvalid && m_axis_tready) begin
            word_t w;
            w.data = m_axis_tdata;
            w.keep = m_axis_tkeep;
            w.last = m_axis_tlast;
            got_q.push_back(w);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = {1'b0, k};
        s_axis_tlast  = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge Aclk);
            ok = s_axis_tready;
            @(posedge Aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_beat accepted=%0b required=1 (byte %h)", ok, d);
        end
    endtask

    // Packing rules: kept bytes fill lanes in order; a word closes on a full word or on tlast.
    task automatic build_expected();
        word_t w;
        int cnt;
        exp_q.delete();
        w = '0;
        cnt = 0;
        foreach (beats_q[i]) begin
            if (beats_q[i].k) begin
                w.data[cnt*8 +: 8] = beats_q[i].d;
                w.keep[cnt] = 1'b1;
                cnt++;
            end
            if (beats_q[i].l || cnt == OB) begin
                w.last = beats_q[i].l;
                exp_q.push_back(w);
                w = '0;
                cnt = 0;
            end
        end
    endtask

    task automatic test_reset();
        Areset_n = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge Aclk);
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h exp 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep got %b exp 0", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", m_axis_tlast); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_sready got %b exp 0", s_axis_tready); end
        s_axis_tvalid = 1'b0;
        @(negedge Aclk);
        Areset_n = 1'b1;
        @(posedge Aclk);
        #1;
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_reset_sready got %b exp 1", s_axis_tready); end
    endtask

    task automatic test_full_word();
        m_axis_tready = 1'b1;
        send_beat(8'h11, 1'b1, 1'b0);
        send_beat(8'h22, 1'b1, 1'b0);
        send_beat(8'h33, 1'b1, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b exp 0", m_axis_tvalid); end
        send_beat(8'h44, 1'b1, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL full_valid got %b exp 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h44332211) begin errors++; $display("FAIL full_data got %h exp 44332211", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 4'b1111) begin errors++; $display("FAIL full_keep got %b exp 1111", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL full_last got %b exp 1", m_axis_tlast); end
        @(posedge Aclk);
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL full_drain got %b exp 0", m_axis_tvalid); end
    endtask

    task automatic test_partial();
        m_axis_tready = 1'b1;
        send_beat(8'hA1, 1'b1, 1'b0);
        send_beat(8'hA2, 1'b1, 1'b0);
        send_beat(8'hA3, 1'b1, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL partial_valid got %b exp 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h00A3A2A1) begin errors++; $display("FAIL partial_data got %h exp 00a3a2a1", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 4'b0111) begin errors++; $display("FAIL partial_keep got %b exp 0111", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL partial_last got %b exp 1", m_axis_tlast); end
    endtask

    task automatic test_backpressure();
        word_t w0, w1;
        w0 = '{data: 32'h04030201, keep: 4'b1111, last: 1'b0};
        w1 = '{data: 32'h08070605, keep: 4'b1111, last: 1'b1};
        @(posedge Aclk);
        #1;
        got_q.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b1, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h05;
        s_axis_tkeep  = 2'b01;
        s_axis_tlast  = 1'b0;
        repeat (5) begin
            @(negedge Aclk);
            checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_sready got %b exp 0", s_axis_tready); end
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", m_axis_tvalid); end
            checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== w0) begin errors++; $display("FAIL bp_hold got %h exp %h", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, w0); end
            @(posedge Aclk);
            #1;
        end
        m_axis_tready = 1'b1;
        for (int i = 5; i <= 8; i++) send_beat(8'(i), 1'b1, i == 8);
        repeat (2) @(posedge Aclk);
        #1;
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL bp_count got %0d exp 2", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== w0) begin errors++; $display("FAIL bp_word0 got %h exp %h", (got_q.size() > 0) ? got_q[0] : '0, w0); end
        checks++; if (got_q.size() < 2 || got_q[1] !== w1) begin errors++; $display("FAIL bp_word1 got %h exp %h", (got_q.size() > 1) ? got_q[1] : '0, w1); end
    endtask

    task automatic test_null();
        m_axis_tready = 1'b1;
        send_beat(8'h00, 1'b0, 1'b1);
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 32'h0, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL null_idx0 got v=%b d=%h k=%b l=%b exp v=1 d=0 k=0 l=1", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        send_beat(8'hAA, 1'b1, 1'b0);
        send_beat(8'h77, 1'b0, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", m_axis_tvalid); end
        send_beat(8'hBB, 1'b1, 1'b1);
        checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {32'h0000BBAA, 4'b0011, 1'b1}) begin
            errors++; $display("FAIL drop_word got d=%h k=%b l=%b exp d=0000bbaa k=0011 l=1", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
        send_beat(8'hCC, 1'b1, 1'b0);
        send_beat(8'h00, 1'b0, 1'b1);
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {1'b1, 32'h000000CC, 4'b0001, 1'b1}) begin
            errors++; $display("FAIL null_close got v=%b d=%h k=%b l=%b exp v=1 d=000000cc k=0001 l=1", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge Aclk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send_beat(8'(8'hD0 + i), 1'b1, 1'b0);
        #2;
        Areset_n = 1'b0;
        #1;
        checks++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready} !== '0) begin
            errors++; $display("FAIL rst_held got v=%b d=%h k=%b l=%b r=%b exp all 0", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready);
        end
        @(negedge Aclk);
        Areset_n = 1'b1;
        @(posedge Aclk);
        #1;
        m_axis_tready = 1'b1;
        send_beat(8'hE1, 1'b1, 1'b0);
        send_beat(8'hE2, 1'b1, 1'b0);
        #2;
        Areset_n = 1'b0;
        #1;
        checks++; if ({m_axis_tvalid, s_axis_tready} !== 2'b00) begin errors++; $display("FAIL rst_partial got v=%b r=%b exp 0 0", m_axis_tvalid, s_axis_tready); end
        @(negedge Aclk);
        Areset_n = 1'b1;
        @(posedge Aclk);
        #1;
        for (int i = 0; i < 4; i++) send_beat(8'(8'h55 + i), 1'b1, i == 3);
        checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {32'h58575655, 4'b1111, 1'b1}) begin
            errors++; $display("FAIL rst_next got d=%h k=%b l=%b exp d=58575655 k=1111 l=1", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end
    endtask

    task automatic test_random();
        beat_t b;
        @(posedge Aclk);
        #1;
        got_q.delete();
        beats_q.delete();
        for (int c = 0; c < 800; c++) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            s_axis_tdata  = 8'($urandom);
            s_axis_tkeep  = {1'($urandom), ($urandom_range(0, 9) != 0)};
            s_axis_tlast  = ($urandom_range(0, 7) == 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            @(negedge Aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                b.d = s_axis_tdata;
                b.k = s_axis_tkeep[0];
                b.l = s_axis_tlast;
                beats_q.push_back(b);
            end
            @(posedge Aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) @(posedge Aclk);
        #1;
        build_expected();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_word[%0d] got %h exp %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
    endtask

`ifdef AXIS_PACK_STATS_EN
    task automatic test_stats();
        Areset_n = 1'b0;
        #3;
        @(negedge Aclk);
        Areset_n = 1'b1;
        @(posedge Aclk);
        #1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(8'(i), 1'b1, i == 3);
        for (int i = 0; i < 3; i++) send_beat(8'(i), 1'b1, i == 2);
        send_beat(8'h9F, 1'b1, 1'b1);
        repeat (3) @(posedge Aclk);
        #1;
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL stats_pkt got %0d exp 3", pkt_count); end
        checks++; if (byte_count !== 32'd8) begin errors++; $display("FAIL stats_bytes got %0d exp 8", byte_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_null();
        test_reset_mid();
        test_random();
`ifdef AXIS_PACK_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_byte_packer.md
Name: axis_byte_packer

Overview:
- Downstream consumer of the 8-bit AXI Stream FIFO.
- Packs 8-bit byte beats into OUT_BYTES-wide little-endian words with per-lane tkeep and tlast preserved.
- Feeds wide-datapath sinks (DMA/bus bridges).
- Registered output stage with full AXI Stream valid/ready backpressure on both sides.

Parameters:
- OUT_BYTES, 4: output word width in bytes; power of two, 2..8.
- IDX_W, $clog2(OUT_BYTES): lane index width; derived, not overridden.

Ports:
- Aclk  input  1  clock; all logic on rising edge.
- Areset_n  input  1  reset, asynchronous, active-low.
- s_axis_tvalid  input  1  upstream byte valid.
- s_axis_tready  output  1  packer accepts a byte this cycle.
- s_axis_tdata  input  8  byte payload.
- s_axis_tkeep  input  2  bit0 = byte valid; bit1 ignored.
- s_axis_tlast  input  1  last byte of packet.
- m_axis_tvalid  output  1  packed word valid.
- m_axis_tready  input  1  downstream accepts word.
- m_axis_tdata  output  8*OUT_BYTES  packed word; first byte in [7:0].
- m_axis_tkeep  output  OUT_BYTES  lane valid mask.
- m_axis_tlast  output  1  word ends a packet.

Behaviour:
- Reset (async, Areset_n low): all outputs 0; s_axis_tready 0 while in reset; lane index 0; accumulator 0; state IDLE. Reset mid-packet discards the partial word and any held output word.
- Input accept: s_axis_tready = !m_axis_tvalid || m_axis_tready (output slot free or draining this cycle). A beat is accepted when s_axis_tvalid && s_axis_tready.
- Accepted beat with tkeep[0]=1: byte written to lane idx, keep bit idx set, idx += 1.
- Accepted beat with tkeep[0]=0 and tlast=0: dropped; no state change.
- Word completion occurs when the accepted beat fills lane OUT_BYTES-1, or the accepted beat has tlast=1.
  - The accumulator (including the current byte) is copied into the output register in the same edge.
  - m_axis_tlast = beat tlast.
  - Unfilled lanes: data 0, keep 0.
  - idx and accumulator are cleared.
- Null terminator: tlast=1 with tkeep[0]=0 at idx 0 emits one word with tkeep=0, tdata=0, tlast=1. At idx>0 it closes the partial word with tlast=1.
- Latency: word visible on m_axis_* exactly 1 cycle after the completing byte is accepted.
- Output register: m_axis_tvalid set on completion. It clears on an m_axis_tvalid && m_axis_tready handshake unless a completion occurs in the same cycle, in which case the new word loads and tvalid stays 1. Throughput: 1 byte/cycle sustained under continuous m_axis_tready.
- Stability: while m_axis_tvalid && !m_axis_tready, m_axis_tdata/tkeep/tlast hold and no input is accepted.
- States:
  - IDLE: idx=0.
  - ACCUM: 0<idx<OUT_BYTES.
  - Transitions: IDLE->ACCUM on a kept byte that does not complete the word. ACCUM->IDLE on completion. IDLE->IDLE on a single-byte tlast or null terminator.
- idx is IDX_W bits and never wraps past OUT_BYTES-1; completion clears it.

Optional Feature:
- Macro AXIS_PACK_STATS_EN.
- Defined: adds outputs pkt_count (16 bits) and byte_count (32 bits).
  - pkt_count += 1 per output word handshake with tlast=1.
  - byte_count += popcount(m_axis_tkeep) per output handshake.
  - Both wrap modulo 2^N and reset to 0.
- Not defined: ports and counters absent; core behaviour identical.

Decomposition:
- Package axis_pack_pkg: state enum pack_state_e {IDLE, ACCUM}; constant DEF_OUT_BYTES=4; function popcount for the keep mask.
- One sub-module, axis_out_slice: parameterised output register (data/keep/last, valid/ready hold logic). Reused by other codebase stream stages.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 (last on 0x44), m_ready=1 -> one word tdata=0x44332211, tkeep=4'b1111, tlast=1, one cycle after 0x44 is accepted.
- Bytes 0xA1,0xA2,0xA3 with tlast on 0xA3 -> tdata=0x00A3A2A1, tkeep=4'b0111, tlast=1.
- Eight bytes 0x01..0x08 (tlast on 0x08), m_ready held 0 for 5 cycles after the first word -> word 0x04030201 holds stable; s_ready=0 while held; then 0x08070605 with tlast=1; no bytes lost.
- Null terminator (tkeep=0, tlast=1) at idx 0 -> word tkeep=0, tdata=0, tlast=1. Beat with tkeep=0, tlast=0 -> no output, idx unchanged.
- Reset asserted after 2 bytes of a packet -> outputs 0 immediately. Next packet 0x55..0x58 packs to 0x58575655 with no stale lanes.
- With AXIS_PACK_STATS_EN: 3 packets of 4, 3 and 1 bytes -> pkt_count=3, byte_count=8.
